param_updown_counter: RTL
=========================

// Module: param_updown_counter
// PURPOSE
//  Parametrised WIDTH-bit modulo-N up/down counter with synchronous load and a registered
//  terminal-count pulse. Successor to the fixed 8-bit enable/clear T-flip-flop counter. Drives
//  hex displays through the seven-segment decoders and cascades via tc into further counters.
//  An optional prescaler turns the 50 MHz board clock into a human-visible count rate.
// PARAMETERS
//  WIDTH     8           counter width in bits (>=2)
//  PRESCALE  50_000_000  clk cycles per count tick when COUNTER_PRESCALE_EN is defined (>=1)
// PORTS
//  clk       in   1      single clock, rising edge
//  clear_b   in   1      reset, asynchronous, active-low
//  enable    in   1      count enable; counter holds when 0
//  up        in   1      direction: 1 = increment, 0 = decrement
//  load      in   1      synchronous load of load_val (overrides enable)
//  load_val  in   WIDTH  value written on load
//  modulus   in   WIDTH  count range 0..modulus-1; 0 selects full range 0..2^WIDTH-1
//  q         out  WIDTH  current count
//  tc        out  1      terminal-count pulse, one clk wide
// BEHAVIOUR
//  - Reset (clear_b=0, asynchronous): q=0, tc=0, prescaler count=0. Hold while low; resume on the
//    first rising clk edge after release.
//  - Per rising edge, priority: load > tick > hold.
//  - load=1: q<=load_val as-is (no range check); tc<=0; prescaler count<=0.
//  - tick = enable (no macro), or enable AND prescaler at PRESCALE-1 (with macro).
//  - Up tick: if q >= LAST then q<=0, wrap; else q<=q+1.
//  - Down tick: if q==0 then q<=LAST, wrap; else q<=q-1.
//  - LAST = modulus-1 when modulus!=0, else {WIDTH{1'b1}}. All arithmetic is modulo 2^WIDTH.
//  - Out-of-range q (loaded >= modulus): an up tick wraps to 0; a down tick decrements normally.
//  - tc is registered: tc<=1 on the edge where a wrap occurs, 0 on every other edge.
//    It is high for exactly the one cycle in which q shows the wrapped value.
//  - up, modulus and load_val are sampled every edge; a change takes effect on the next tick.
//  - modulus==1: every tick gives q=0 with tc=1.
//  - enable=0 with load=0: q holds, tc<=0, prescaler holds its value (it is not cleared).
// CONFIGURATION
//  - COUNTER_PRESCALE_EN defined: an internal counter of $clog2(PRESCALE) bits advances on each
//    enable cycle. It yields tick at PRESCALE-1 and then returns to 0. PRESCALE=1 is equivalent
//    to no prescaler.
//  - COUNTER_PRESCALE_EN undefined: no prescaler logic; tick = enable; PRESCALE is ignored.
// STRUCTURE
//  - Shared package counter_pkg: CNT_UP=1'b1 and CNT_DN=1'b0 constants, plus a function
//    last_val(modulus) returning LAST. Both are reused by the display and timer blocks.
//  - One sub-module: rate_divider (clk, clear_b, enable, clr, tick). It is instantiated only
//    under COUNTER_PRESCALE_EN; clr is driven by load.
//  - Top level: next-state mux, q register and tc register.
// TESTING
//  1. Reset mid-count: WIDTH=8, modulus=0, count to 0x37, pull clear_b low between edges
//     -> q=0 and tc=0 immediately, no clk edge needed.
//  2. Up wrap: modulus=10, up=1, enable=1, 10 ticks from 0 -> q=0..9,0; tc high only in the
//     cycle with q=0 after 9.
//  3. Down wrap full range: modulus=0, load 0x01, down, 2 ticks -> q=0x00 then 0xFF, tc=1 in the
//     0xFF cycle.
//  4. Load priority: enable=1, load=1, load_val=0x42 at q=0x10 -> q=0x42 next, tc=0; load_val=12
//     with modulus=10, up tick -> q=0, tc=1.
//  5. Direction change: modulus=16, q=5, alternate up/down each tick for 4 ticks -> q=6,5,6,5
//     with no tc.
//  6. Prescaler (macro on, PRESCALE=4): enable=1 for 12 cycles -> q steps every 4th cycle to 3;
//     enable=0 for 2 cycles mid-period -> step delayed by exactly 2 cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the counter family (up/down counter, display and
//   timer blocks).
//   Contents:
//     CNT_UP / CNT_DN : encodings of the 'up' direction input
//     last_val()      : highest count value for a given modulus and width
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Highest value the counter reaches before wrapping.
    // A modulus of zero selects the full binary range of 'width' bits.
    // Callers zero-extend the modulus to 32 bits and truncate the result
    // back to their own width; widths above 32 are not supported.
    function automatic logic [31:0] last_val(
        input logic [31:0] modulus,
        input int unsigned width
    );
        logic [31:0] result;
        if (modulus != 32'd0) begin
            result = modulus - 32'd1;
        end else begin
            result = 32'hFFFF_FFFF >> (32'd32 - width);
        end
        return result;
    endfunction

endpackage : counter_pkg

// File: rtl/rate_divider.sv
// -----------------------------------------------------------------------------
// rate_divider
//   Divides the enable stream down to one tick every PRESCALE enabled cycles.
//   The internal count advances only on cycles where enable is high, so
//   pausing enable stretches the period by exactly the paused cycles.
//   Parameters:
//     PRESCALE : enabled clk cycles per tick (>= 1; 1 gives tick = enable)
//   Ports:
//     clk     in  rising-edge clock
//     clear_b in  asynchronous active-low reset, clears the count
//     enable  in  advance the count this cycle
//     clr     in  synchronous clear of the count (has priority over enable)
//     tick    out high on the enabled cycle where the count is PRESCALE-1
// -----------------------------------------------------------------------------
module rate_divider #(
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic clk,
    input  logic clear_b,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    // A one-bit count is kept even when PRESCALE is 1; it then never leaves 0.
    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last_s;

    assign at_last_s = (cnt_q == CNT_LAST);
    assign tick      = enable & at_last_s;

    // Next-count selection: clear, advance/roll over, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (enable) begin
            if (at_last_s) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : rate_divider

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//   WIDTH-bit modulo-N up/down counter with synchronous load and a registered
//   one-cycle terminal-count pulse for cascading.
//   Configuration macro:
//     COUNTER_PRESCALE_EN : when defined, counting is slowed by a rate_divider
//                           so that one step happens every PRESCALE enabled
//                           cycles. When undefined every enabled cycle steps
//                           and PRESCALE is ignored.
//   Parameters:
//     WIDTH    : counter width in bits (2..32)
//     PRESCALE : enabled clk cycles per step with the prescaler built in
//   Ports:
//     clk      in  rising-edge clock
//     clear_b  in  asynchronous active-low reset (q, tc, prescaler to 0)
//     enable   in  count enable; counter holds when low
//     up       in  direction, CNT_UP increments, CNT_DN decrements
//     load     in  synchronous load of load_val, overrides enable
//     load_val in  value written on load (taken as-is, no range check)
//     modulus  in  count range 0..modulus-1; 0 selects 0..2^WIDTH-1
//     q        out current count (registered)
//     tc       out terminal-count pulse, high in the cycle q shows a wrap
// -----------------------------------------------------------------------------
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick_s;
    logic [WIDTH-1:0] last_s;

`ifdef COUNTER_PRESCALE_EN
    // A load restarts the prescale period so the first step after a load
    // always comes a full period later.
    rate_divider #(
        .PRESCALE (PRESCALE)
    ) u_rate_divider (
        .clk     (clk),
        .clear_b (clear_b),
        .enable  (enable),
        .clr     (load),
        .tick    (tick_s)
    );
`else
    logic [31:0] prescale_unused_s;

    assign prescale_unused_s = PRESCALE;
    assign tick_s            = enable;
`endif

    assign last_s = WIDTH'(last_val(32'(modulus), WIDTH));

    // Next-state mux: load beats tick beats hold. tc_d marks a wrap.
    // Up uses >= so an out-of-range loaded value wraps to 0 on the next
    // up step; down only wraps from exactly 0, so out-of-range values
    // simply decrement back into range.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            q_d  = load_val;
            tc_d = 1'b0;
        end else if (tick_s) begin
            if (up == CNT_UP) begin
                if (q_q >= last_s) begin
                    q_d  = ZERO;
                    tc_d = 1'b1;
                end else begin
                    q_d  = q_q + ONE;
                    tc_d = 1'b0;
                end
            end else begin
                if (q_q == ZERO) begin
                    q_d  = last_s;
                    tc_d = 1'b1;
                end else begin
                    q_d  = q_q - ONE;
                    tc_d = 1'b0;
                end
            end
        end else begin
            q_d  = q_q;
            tc_d = 1'b0;
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            q_q  <= ZERO;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

endmodule : param_updown_counter
